// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin search used by stream_mux_rr and future arbiters.
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

    localparam int RR_MAX_N = 16;

    typedef struct packed {
        logic       gvalid;
        logic [3:0] idx;
    } rr_grant_t;

    // Lowest offset k in 1..n from ptr wins; the loop runs downward so that
    // the last assignment comes from the smallest offset.
    function automatic rr_grant_t rr_next(input logic [3:0] ptr,
                                          input logic [RR_MAX_N-1:0] valid_vec,
                                          input int n);
        rr_grant_t g;
        int        idx;
        g = '0;
        for (int k = RR_MAX_N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && valid_vec[idx[3:0]]) begin
                g.gvalid = 1'b1;
                g.idx    = idx[3:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_n_1_slice.sv
// One narrow bit-slice of the N:1 data mux; out-of-range select yields zero.
module mux_n_1_slice #(
    parameter int N_IN    = 4,
    parameter int SLICE_W = 2,
    parameter int SEL_W   = $clog2(N_IN)
) (
    input  logic [N_IN*SLICE_W-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    output logic [SLICE_W-1:0]      y
);

    // Only the selected lane is ever read, so X on other lanes cannot leak.
    always_comb begin
        y = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(sel) == i) y = data[i*SLICE_W +: SLICE_W];
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream mux with fixed/round-robin arbitration into a single output register.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_IN    = 4,
    parameter  int W       = 8,
    parameter  int SLICE_W = 2,
    localparam int SEL_W   = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [N_IN*W-1:0] in_data,
    output logic [N_IN-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_src,
    input  logic              out_ready
);

    localparam int N_SLICE = W / SLICE_W;

    if (W % SLICE_W != 0) begin : g_bad_slice
        $error("stream_mux_rr: W must be a multiple of SLICE_W");
    end

    logic                 load_en;
    logic                 grant_valid;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     rr_ptr;
    logic [W-1:0]         next_data;
    logic [RR_MAX_N-1:0]  valid_ext;
    rr_grant_t            rr_g;

    assign load_en   = !out_valid || out_ready;
    assign valid_ext = RR_MAX_N'(in_valid);
    assign rr_g      = rr_next(4'(rr_ptr), valid_ext, N_IN);

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mux_mode_t'(mode) == MODE_RR) begin
            grant_valid = rr_g.gvalid;
            grant       = SEL_W'(rr_g.idx);
        end else if (int'(sel) < N_IN) begin
            grant_valid = valid_ext[4'(sel)];
            grant       = sel;
        end
        if (!load_en) grant_valid = 1'b0;
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = grant_valid && (int'(grant) == i);
        end
    end

    for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
        logic [N_IN*SLICE_W-1:0] sd;
        for (genvar i = 0; i < N_IN; i++) begin : g_ch
            assign sd[i*SLICE_W +: SLICE_W] = in_data[i*W + s*SLICE_W +: SLICE_W];
        end
        mux_n_1_slice #(.N_IN(N_IN), .SLICE_W(SLICE_W), .SEL_W(SEL_W)) u_mux (
            .data (sd),
            .sel  (grant),
            .y    (next_data[s*SLICE_W +: SLICE_W])
        );
    end

    // grant_valid already folds in load_en, so it marks an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(N_IN - 1);
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= next_data;
                out_src  <= grant;
                rr_ptr   <= grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed checks on three parameterisations plus a scoreboarded random stream.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // N_IN=4, W=8
    logic m4 = 0, or4 = 0, ov4;
    logic [1:0] s4 = 0, os4;
    logic [3:0] v4 = 0, r4;
    logic [31:0] d4 = 0;
    logic [7:0] od4;
    stream_mux_rr #(.N_IN(4), .W(8), .SLICE_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mode(m4), .sel(s4), .in_valid(v4), .in_data(d4),
        .in_ready(r4), .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(or4));

    // N_IN=3, W=8
    logic m3 = 0, or3 = 0, ov3;
    logic [1:0] s3 = 0, os3;
    logic [2:0] v3 = 0, r3;
    logic [23:0] d3 = 0;
    logic [7:0] od3;
    stream_mux_rr #(.N_IN(3), .W(8), .SLICE_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(m3), .sel(s3), .in_valid(v3), .in_data(d3),
        .in_ready(r3), .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(or3));

    // N_IN=5, W=12, SLICE_W=4
    logic m5 = 0, or5 = 0, ov5;
    logic [2:0] s5 = 0, os5;
    logic [4:0] v5 = 0, r5;
    logic [59:0] d5 = 0;
    logic [11:0] od5;
    stream_mux_rr #(.N_IN(5), .W(12), .SLICE_W(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(m5), .sel(s5), .in_valid(v5), .in_data(d5),
        .in_ready(r5), .out_valid(ov5), .out_data(od5), .out_src(os5), .out_ready(or5));

    logic [7:0]  ch4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [11:0] cd [5];
    logic [15:0] sbq [$];
    logic [4:0]  acc;
    int          pops = 0;
    int          cyc = 0;
    int          seq3 [4] = '{0, 3, 0, 3};

    initial begin
        // reset state
        #3;
        chk("rst_ov", ov4, 0);
        chk("rst_od", od4, 0);
        chk("rst_os", os4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fixed select
        m4 = 0; s4 = 2; v4 = 4'b1111; or4 = 1;
        d4 = {ch4[3], ch4[2], ch4[1], ch4[0]};
        #1 chk("fix_ready", r4, 4'b0100);
        tick;
        chk("fix_ov", ov4, 1);
        chk("fix_od", od4, 8'h33);
        chk("fix_os", os4, 2);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_ov", ov4, 0);
        chk("async_rst_od", od4, 0);
        #1 rst_n = 1'b1;

        // round-robin, all valid
        m4 = 1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("rr_os", os4, k % 4);
            chk("rr_od", od4, ch4[k % 4]);
            chk("rr_ov", ov4, 1);
        end

        // sparse round-robin with wrap
        v4 = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("sparse_os", os4, seq3[k]);
        end
        v4 = 0;
        tick;
        chk("idle_ov", ov4, 0);
        chk("idle_od_hold", od4, 8'h44);

        // backpressure
        m4 = 0; s4 = 1; v4 = 4'b0010; d4[15:8] = 8'hA5;
        tick;
        chk("bp_load_od", od4, 8'hA5);
        chk("bp_load_os", os4, 1);
        or4 = 0; d4[15:8] = 8'h5A;
        #1 chk("bp_ready0", r4, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("bp_hold_od", od4, 8'hA5);
            chk("bp_hold_ov", ov4, 1);
            chk("bp_ready", r4, 0);
        end
        or4 = 1;
        #1 chk("pop_load_ready", r4, 4'b0010);
        tick;
        chk("pop_load_od", od4, 8'h5A);
        chk("pop_load_ov", ov4, 1);
        v4 = 0;
        tick;
        chk("drain_ov", ov4, 0);

        // out-of-range select and X on ungranted lane
        m3 = 0; s3 = 3; v3 = 3'b111; or3 = 1;
        d3 = {8'h03, 8'h0A, 8'h01};
        #1 chk("oor_ready", r3, 0);
        tick;
        chk("oor_ov", ov3, 0);
        s3 = 1; d3[23:16] = 'x;
        #1 chk("x_ready", r3, 3'b010);
        tick;
        chk("x_od", od3, 8'h0A);
        chk("x_os", os3, 1);
        v3 = 0;

        // random round-robin stream with scoreboard
        m5 = 1;
        for (int i = 0; i < 5; i++) cd[i] = 'x;
        while (pops < 200 && cyc < 5000) begin
            for (int i = 0; i < 5; i++) begin
                if (!v5[i] && $urandom_range(0, 3) != 0) begin
                    v5[i] = 1'b1;
                    cd[i] = 12'($urandom);
                end
                d5[i*12 +: 12] = cd[i];
            end
            or5 = ($urandom_range(0, 3) != 0);
            #1;
            if (ov5 && or5) begin
                int j;
                j = -1;
                for (int q = 0; q < sbq.size(); q++) begin
                    if (j < 0 && sbq[q][15:12] == {1'b0, os5}) j = q;
                end
                chk("sb_found", (j >= 0), 1);
                if (j >= 0) begin
                    chk("sb_data", od5, sbq[j][11:0]);
                    sbq.delete(j);
                end
                pops++;
            end
            acc = v5 & r5;
            for (int i = 0; i < 5; i++) begin
                if (acc[i]) sbq.push_back({4'(i), cd[i]});
            end
            tick;
            cyc++;
            for (int i = 0; i < 5; i++) begin
                if (acc[i]) begin
                    v5[i] = 1'b0;
                    cd[i] = 'x;
                end
            end
        end
        chk("sb_count", pops, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two arbitration modes: fixed select (software-style `sel`) and round-robin across valid inputs.
- Datapath is built from replicated narrow-slice muxes; the result is captured in a single-entry output register.
- Sits between multiple producer streams and one consumer; generalises the 4:1 2-bit-slice mux to N inputs, any width, and sequential flow control.

Parameters:
- N_IN, 4, number of input channels (2..16; need not be a power of two).
- W, 8, data width per channel.
- SLICE_W, 2, width of one narrow mux slice; W must be a multiple of SLICE_W (elaboration-time check).
- SEL_W, $clog2(N_IN), width of select/source fields (localparam).

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- mode, input, 1, 0 = fixed select, 1 = round-robin.
- sel, input, SEL_W, channel chosen in fixed mode; ignored in round-robin.
- in_valid, input, N_IN, per-channel valid.
- in_data, input, N_IN*W, channel i occupies bits [i*W +: W].
- in_ready, output, N_IN, per-channel ready; at most one bit high per cycle.
- out_valid, output, 1, output register holds a word.
- out_data, output, W, registered data.
- out_src, output, SEL_W, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=N_IN-1, so channel 0 has first priority. Reset asserted mid-transfer discards the held word immediately.
- load_en = !out_valid || out_ready. This is a pipeline register with no skid buffer; full throughput is 1 word/cycle.
- Arbitration is combinational, evaluated only when load_en=1:
  - Fixed mode: grant = sel if sel < N_IN and in_valid[sel]; otherwise no grant. If sel >= N_IN, no grant and all in_ready are low.
  - Round-robin mode: grant = first i with in_valid[i]=1, searching from rr_ptr+1 upward with wrap modulo N_IN; no grant if all in_valid are low.
- in_ready[i] = load_en && grant_valid && grant==i. Transfer on input i occurs when in_valid[i] && in_ready[i].
- On a clock edge with load_en=1:
  - out_valid <= grant_valid.
  - If grant_valid: out_data <= in_data[grant], out_src <= grant.
  - If no grant: out_data and out_src hold their previous values.
- Stall (out_valid=1, out_ready=0): out_valid, out_data and out_src are held stable; all in_ready are low.
- rr_ptr <= grant only on an input transfer. It is also updated in fixed mode, so switching to round-robin continues fairly from the last served channel.
- mode and sel are sampled combinationally each cycle. A change takes effect at the next arbitration; a word already in the register is unaffected.
- Latency: input transfer at edge k gives out_valid=1 after edge k. With out_ready held high, back-to-back words stream at one per cycle.
- Simultaneous output pop and input load in the same cycle is legal and required.
- Inputs are assumed to follow the valid/ready protocol: in_data is stable while in_valid=1 and not accepted. The block does not check this.
- Invalid channel data may be X. X on a non-granted channel must never reach out_data (bench checks with !==).

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum logic {MODE_FIXED=0, MODE_RR=1} mux_mode_t.
  - Function rr_next(ptr, valid_vec) returning grant index and grant_valid, shared with future arbiters.
- Sub-module mux_n_1_slice:
  - Parametrised N_IN, SLICE_W; inputs flattened data plus SEL_W select; combinational.
  - Instantiated W/SLICE_W times via generate, one per bit-slice.
  - Slice outputs concatenated in bit order to form the registered next-data.

Test Plan:
- Reset and fixed select: N_IN=4, W=8, mode=0, sel=2, in_valid=4'b1111, data {0x11,0x22,0x33,0x44} for ch0..3, out_ready=1. Expect in_ready=4'b0100, and after one edge out_valid=1, out_data=0x33, out_src=2. Assert rst_n low mid-stream: out_valid drops to 0 immediately, without waiting for an edge.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles. Expect out_src sequence 0,1,2,3,0,1,2,3 with one word per cycle.
- Sparse round-robin with wrap: in_valid=4'b1001 held. Expect out_src sequence 0,3,0,3. Then in_valid=0: out_valid=0 next cycle, and out_data holds its last value.
- Backpressure: out_ready=0 for 3 cycles with a word held (0xA5, src 1). Expect out_data=0xA5 stable, in_ready=0 throughout. Raise out_ready: pop and new load happen in the same cycle, with no bubble.
- Out-of-range and X: N_IN=3, mode=0, sel=3. Expect in_ready=0 and out_valid=0. Then sel=1 with ch2 data='x: expect out_data equal to ch1 data (e.g. 0x0A), checked with !==.
- Width sweep: W=12, SLICE_W=4, N_IN=5, round-robin with random data for 200 transfers. A scoreboard checks per-source order and data integrity.
